// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory between the processor datapath (C)
// and the host/loader (H): round-robin on conflict, host lock with bounded starvation.
module mem_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_H = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    state_t      state_r, state_next_s;
    logic [7:0]  lock_cnt_r, lock_cnt_next_s;
    logic        c_gnt_s, h_gnt_s;
    logic        c_rvalid_r, h_rvalid_r;

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        c_gnt_s = 1'b0;
        h_gnt_s = 1'b0;
        if (!Reset) begin
            c_gnt_s = 1'b0;
            h_gnt_s = 1'b0;
        end else if (c_req && h_req) begin
            if (h_lock) begin
                // Host keeps priority until C has waited LOCK_MAX host grants
                if (lock_cnt_r == LOCK_MAX_C) begin
                    c_gnt_s = 1'b1;
                end else begin
                    h_gnt_s = 1'b1;
                end
            end else begin
                case (state_r)
                    OWN_C:   h_gnt_s = 1'b1;
                    default: c_gnt_s = 1'b1;
                endcase
            end
        end else if (c_req) begin
            c_gnt_s = 1'b1;
        end else if (h_req) begin
            h_gnt_s = 1'b1;
        end else begin
            c_gnt_s = 1'b0;
            h_gnt_s = 1'b0;
        end
    end

    // Next owner and lock-starvation counter
    always_comb begin
        state_next_s    = IDLE;
        lock_cnt_next_s = lock_cnt_r;
        if (c_gnt_s) begin
            state_next_s = OWN_C;
        end else if (h_gnt_s) begin
            state_next_s = OWN_H;
        end else begin
            state_next_s = IDLE;
        end

        if (c_gnt_s || !c_req) begin
            lock_cnt_next_s = 8'd0;
        end else if (h_gnt_s && h_lock && (lock_cnt_r < LOCK_MAX_C)) begin
            lock_cnt_next_s = lock_cnt_r + 8'd1;
        end else begin
            lock_cnt_next_s = lock_cnt_r;
        end
    end

    // State, counter and read-valid registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r    <= IDLE;
            lock_cnt_r <= 8'd0;
            c_rvalid_r <= 1'b0;
            h_rvalid_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            lock_cnt_r <= lock_cnt_next_s;
            c_rvalid_r <= c_gnt_s & ~c_we;
            h_rvalid_r <= h_gnt_s & ~h_we;
        end
    end

    // Memory command mux from the granted requester
    always_comb begin
        m_en    = c_gnt_s | h_gnt_s;
        m_we    = 1'b0;
        m_addr  = {AW{1'b0}};
        m_wdata = {DW{1'b0}};
        if (c_gnt_s) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (h_gnt_s) begin
            m_we    = h_we;
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end else begin
            m_we    = 1'b0;
            m_addr  = {AW{1'b0}};
            m_wdata = {DW{1'b0}};
        end
    end

    assign c_gnt    = c_gnt_s;
    assign h_gnt    = h_gnt_s;
    assign c_rvalid = c_rvalid_r;
    assign h_rvalid = h_rvalid_r;
    assign c_rdata  = c_rvalid_r ? m_rdata : {DW{1'b0}};
    assign h_rdata  = h_rvalid_r ? m_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle-latency memory.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt, c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          h_gnt, h_rvalid;
    logic [DW-1:0] h_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (m_en && m_we) mem[m_addr] <= m_wdata;
        if (m_en && !m_we) m_rdata <= mem[m_addr];
    end

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; h_req = 1'b0; h_we = 1'b0; h_lock = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; c_req = 1'b1; h_req = 1'b1;
        tick(); tick();
        checks++; if (c_gnt !== 1'b0 || h_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt c=%b h=%b want 0 0", c_gnt, h_gnt); end
        checks++; if (m_en !== 1'b0 || m_addr !== 5'h00) begin errors++; $display("FAIL reset_mem m_en=%b m_addr=%h want 0 00", m_en, m_addr); end
        checks++; if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid c=%b h=%b want 0 0", c_rvalid, h_rvalid); end
        Reset = 1'b1;
        #1;
        checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin errors++; $display("FAIL reset_first_grant c=%b h=%b want 1 0", c_gnt, h_gnt); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_read();
        h_req = 1'b1; h_we = 1'b1; h_addr = 5'h03; h_wdata = 8'hA5;
        #1;
        checks++; if (h_gnt !== 1'b1 || m_we !== 1'b1 || m_wdata !== 8'hA5) begin errors++; $display("FAIL h_write_cmd gnt=%b we=%b wdata=%h want 1 1 a5", h_gnt, m_we, m_wdata); end
        tick();
        idle_inputs();
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h03;
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL h_write_rvalid got %b want 0", h_rvalid); end
        #1;
        checks++; if (c_gnt !== 1'b1 || m_addr !== 5'h03 || m_en !== 1'b1) begin errors++; $display("FAIL c_read_cmd gnt=%b addr=%h en=%b want 1 03 1", c_gnt, m_addr, m_en); end
        tick();
        idle_inputs();
        checks++; if (c_rvalid !== 1'b1 || c_rdata !== 8'hA5 || h_rvalid !== 1'b0) begin errors++; $display("FAIL c_read_data rv=%b data=%h hrv=%b want 1 a5 0", c_rvalid, c_rdata, h_rvalid); end
        tick();
        checks++; if (c_rvalid !== 1'b0 || c_rdata !== 8'h00) begin errors++; $display("FAIL c_read_idle rv=%b data=%h want 0 00", c_rvalid, c_rdata); end
    endtask

    task automatic test_round_robin();
        logic exp_c;
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h01;
        h_req = 1'b1; h_we = 1'b0; h_addr = 5'h02; h_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_c = (i % 2 == 0);
            #1;
            checks++; if (c_gnt !== exp_c || h_gnt !== !exp_c || m_addr !== (exp_c ? 5'h01 : 5'h02)) begin
                errors++; $display("FAIL rr_cycle%0d c=%b h=%b addr=%h want c=%b", i, c_gnt, h_gnt, m_addr, exp_c);
            end
            tick();
            checks++; if (c_rvalid !== exp_c || h_rvalid !== !exp_c) begin
                errors++; $display("FAIL rr_rvalid%0d c=%b h=%b want c=%b", i, c_rvalid, h_rvalid, exp_c);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        logic exp_c;
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h01;
        h_req = 1'b1; h_we = 1'b0; h_addr = 5'h02; h_lock = 1'b1;
        for (int i = 0; i < 19; i++) begin
            exp_c = (i == 8) || (i == 17);
            #1;
            checks++; if (c_gnt !== exp_c || h_gnt !== !exp_c) begin
                errors++; $display("FAIL lock_cycle%0d c=%b h=%b want c=%b", i, c_gnt, h_gnt, exp_c);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read();
        h_req = 1'b1; h_we = 1'b1; h_addr = 5'h1F; h_wdata = 8'h3C;
        tick();
        idle_inputs();
        c_req = 1'b1; c_addr = 5'h1F;
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", h_rvalid); end
        #1;
        checks++; if (c_gnt !== 1'b1 || m_addr !== 5'h1F) begin errors++; $display("FAIL wr_c_cmd gnt=%b addr=%h want 1 1f", c_gnt, m_addr); end
        tick();
        idle_inputs();
        checks++; if (c_rvalid !== 1'b1 || c_rdata !== 8'h3C) begin errors++; $display("FAIL wr_c_data rv=%b data=%h want 1 3c", c_rvalid, c_rdata); end
        tick();
    endtask

    task automatic test_simul();
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h03;
        h_req = 1'b1; h_we = 1'b1; h_addr = 5'h03; h_wdata = 8'h5A;
        #1;
        checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin errors++; $display("FAIL simul_first c=%b h=%b want 1 0", c_gnt, h_gnt); end
        tick();
        c_req = 1'b0;
        checks++; if (c_rdata !== 8'hA5) begin errors++; $display("FAIL simul_old_data got %h want a5", c_rdata); end
        #1;
        checks++; if (h_gnt !== 1'b1 || m_we !== 1'b1 || m_wdata !== 8'h5A) begin errors++; $display("FAIL simul_h_write gnt=%b we=%b wdata=%h want 1 1 5a", h_gnt, m_we, m_wdata); end
        tick();
        idle_inputs();
        c_req = 1'b1; c_addr = 5'h03;
        tick();
        idle_inputs();
        checks++; if (c_rvalid !== 1'b1 || c_rdata !== 8'h5A) begin errors++; $display("FAIL simul_new_data rv=%b data=%h want 1 5a", c_rvalid, c_rdata); end
        tick();
    endtask

    task automatic test_cancel();
        // C write loses to the locked host, then withdraws; memory must stay unchanged
        c_req = 1'b1; c_we = 1'b1; c_addr = 5'h03; c_wdata = 8'hFF;
        h_req = 1'b1; h_we = 1'b0; h_addr = 5'h1F; h_lock = 1'b1;
        #1;
        checks++; if (c_gnt !== 1'b0 || h_gnt !== 1'b1) begin errors++; $display("FAIL cancel_gnt c=%b h=%b want 0 1", c_gnt, h_gnt); end
        tick();
        idle_inputs();
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h03;
        tick();
        idle_inputs();
        checks++; if (c_rdata !== 8'h5A) begin errors++; $display("FAIL cancel_mem got %h want 5a", c_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'h03;
        tick();
        Reset = 1'b0;
        #1;
        checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_rvalid got %b want 0", c_rvalid); end
        tick();
        c_req = 1'b1; h_req = 1'b1; h_lock = 1'b0;
        Reset = 1'b1;
        #1;
        checks++; if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid c=%b h=%b want 0 0", c_rvalid, h_rvalid); end
        checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin errors++; $display("FAIL post_reset_idle c=%b h=%b want 1 0", c_gnt, h_gnt); end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_lock();
        test_write_read();
        test_simul();
        test_cancel();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
